// File: rtl/mux_uart_tx.sv
// MUX port 0 transmit channel: memory-mapped status/data registers on the
// CPU6 bus, a small transmit FIFO, and an 8N1 serializer driving txd.
module mux_uart_tx #(
    parameter logic [18:0] BASE_ADDR    = 19'h3f200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [18:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        select,
    output logic        txd,
    output logic        irq
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam logic [18:0] DATA_ADDR = BASE_ADDR + 19'd1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0] PTR_ONE   = (PW+1)'(1);
    localparam logic [PW:0] FULL_DIFF = {1'b1, {PW{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          ovf, irq_en;
    logic          fifo_full, fifo_empty, tx_idle, tx_ready;
    logic          wr_data, wr_stat, push, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == FULL_DIFF);
    assign tx_ready   = ~fifo_full;
    assign tx_idle    = fifo_empty && (state == S_IDLE);
    assign irq        = tx_idle && irq_en;

    assign wr_data = write_en && (address == DATA_ADDR);
    assign wr_stat = write_en && (address == BASE_ADDR);
    // Fullness is judged before the edge, so a same-cycle pop cannot rescue a write.
    assign push    = wr_data && !fifo_full;

    assign select = (address == BASE_ADDR) || (address == DATA_ADDR);

    // Status readback; every other address reads as zero
    always_comb begin
        data_out = '0;
        if (address == BASE_ADDR)
            data_out = {ovf, 3'b000, tx_idle, irq_en, tx_ready, 1'b0};
    end

    // FIFO storage (no reset needed; validity is tracked by the pointers)
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr[PW-1:0]] <= data_in;
    end

    // FIFO pointers and control/status register bits
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_data && fifo_full)
                ovf <= 1'b1;
            if (wr_stat) begin
                irq_en <= data_in[2];
                if (data_in[7])
                    ovf <= 1'b0;
            end
        end
    end

    // Serializer state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // Serializer next-state, FIFO pop and line level
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        txd       = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr[PW-1:0]];
                    baud_n  = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (baud == BAUD_LAST) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            S_DATA: begin
                txd = shift[0];
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == 3'd7)
                        state_n = S_STOP;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            S_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr[PW-1:0]];
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_uart_tx.sv
// Self-checking bench for mux_uart_tx: register table, serial scoreboard,
// and hand-written timing sequences.
module tb_mux_uart_tx;

    localparam int          CPB  = 16;
    localparam logic [18:0] BASE = 19'h3f200;
    localparam logic [18:0] DATA = 19'h3f201;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [18:0] address = '0;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        select, txd, irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb[$];
    logic       rx_busy = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_byte = '0;
    int         rx_frames = 0;

    typedef struct {
        logic [18:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        logic        exp_sel;
        logic [7:0]  exp_stat;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[9];

    mux_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .address (address),
        .write_en(write_en),
        .data_in (data_in),
        .data_out(data_out),
        .select  (select),
        .txd     (txd),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
        @(negedge clock);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        @(posedge clock);
        #1;
        write_en = 1'b0;
        address  = '0;
    endtask

    task automatic send(input logic [7:0] d, input logic accept);
        if (accept)
            sb.push_back(d);
        bus_write(DATA, d);
    endtask

    task automatic read_status(output logic [7:0] v);
        address = BASE;
        #1;
        v = data_out;
        address = '0;
    endtask

    // Compare txd cycle-by-cycle against n contiguous frames of b0, b1.
    task automatic expect_wave(input string name, input logic [7:0] b0, input logic [7:0] b1,
                               input int n, input logic now);
        int   bad = 0;
        logic [7:0] cur;
        logic want;
        for (int i = 0; i < n * 10 * CPB; i++) begin
            int f, b;
            if (!(now && i == 0)) begin
                @(posedge clock);
                #1;
            end
            f   = i / (10 * CPB);
            b   = (i / CPB) % 10;
            cur = (f == 0) ? b0 : b1;
            if (b == 0)      want = 1'b0;
            else if (b == 9) want = 1'b1;
            else             want = cur[b-1];
            if (txd !== want) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        logic [7:0] st;
        int cnt;

        vecs[0] = '{BASE,          1'b0, 8'h00, 8'h0a, 1'b1, 8'h0a, 1'b0};
        vecs[1] = '{DATA,          1'b0, 8'h00, 8'h00, 1'b1, 8'h0a, 1'b0};
        vecs[2] = '{19'h3f1ff,     1'b0, 8'h00, 8'h00, 1'b0, 8'h0a, 1'b0};
        vecs[3] = '{19'h3f202,     1'b0, 8'h00, 8'h00, 1'b0, 8'h0a, 1'b0};
        vecs[4] = '{BASE,          1'b1, 8'h04, 8'h0e, 1'b1, 8'h0e, 1'b1};
        vecs[5] = '{BASE,          1'b1, 8'h84, 8'h0e, 1'b1, 8'h0e, 1'b1};
        vecs[6] = '{19'h3f1ff,     1'b1, 8'hff, 8'h00, 1'b0, 8'h0e, 1'b1};
        vecs[7] = '{19'h3f202,     1'b1, 8'h00, 8'h00, 1'b0, 8'h0e, 1'b1};
        vecs[8] = '{BASE,          1'b1, 8'h00, 8'h0a, 1'b1, 8'h0a, 1'b0};

        // Serial receiver: decodes txd at mid-bit and pops the scoreboard.
        fork
            forever begin
                @(negedge clock);
                if (!resetn) begin
                    rx_busy = 1'b0;
                end else if (!rx_busy) begin
                    if (txd === 1'b0) begin
                        rx_busy = 1'b1;
                        rx_cnt  = 0;
                    end
                end else begin
                    rx_cnt++;
                    if (rx_cnt == CPB / 2) begin
                        check("rx_start_bit", txd, 1'b0);
                    end else if (rx_cnt > CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2) begin
                        int idx;
                        idx = rx_cnt / CPB - 1;
                        rx_byte[idx] = txd;
                    end else if (rx_cnt == 9 * CPB + CPB / 2) begin
                        check("rx_stop_bit", txd, 1'b1);
                        check("rx_frame_expected", sb.size() > 0, 1'b1);
                        if (sb.size() > 0)
                            check("rx_byte", rx_byte, sb.pop_front());
                        rx_frames++;
                        rx_busy = 1'b0;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_txd", txd, 1'b1);
        check("reset_irq", irq, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        read_status(st);
        check("reset_status", st, 8'h0a);
        check("reset_txd_after", txd, 1'b1);

        // Register table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].we)
                bus_write(vecs[i].addr, vecs[i].wdata);
            address = vecs[i].addr;
            #1;
            check($sformatf("vec%0d_rd", i), data_out, vecs[i].exp_rd);
            check($sformatf("vec%0d_sel", i), select, vecs[i].exp_sel);
            read_status(st);
            check($sformatf("vec%0d_status", i), st, vecs[i].exp_stat);
            check($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
        end

        // Single byte
        send(8'h41, 1'b1);
        check("single_no_early_start", txd, 1'b1);
        expect_wave("single_wave", 8'h41, 8'h00, 1, 1'b0);
        read_status(st);
        check("single_busy_at_160", st, 8'h02);
        @(posedge clock);
        #1;
        read_status(st);
        check("single_idle_at_161", st, 8'h0a);

        // Back-to-back
        send(8'h00, 1'b1);
        send(8'hff, 1'b1);
        expect_wave("b2b_wave", 8'h00, 8'hff, 2, 1'b1);
        @(posedge clock);
        #1;
        read_status(st);
        check("b2b_idle", st, 8'h0a);

        // Overflow
        for (int i = 1; i <= 6; i++)
            send(8'(i), i <= 5);
        read_status(st);
        check("ovf_status", st, 8'h80);
        bus_write(BASE, 8'h80);
        read_status(st);
        check("ovf_cleared", st, 8'h00);
        cnt = rx_frames;
        for (int i = 0; i < 6 * 10 * CPB + 100; i++) begin
            @(posedge clock);
            if (sb.size() == 0 && !rx_busy) break;
        end
        check("ovf_drain_empty", sb.size(), 0);
        check("ovf_frames", rx_frames - cnt, 5);
        repeat (20) @(posedge clock);
        #1;
        read_status(st);
        check("ovf_final_status", st, 8'h0a);

        // Interrupt
        bus_write(BASE, 8'h04);
        check("irq_idle_enabled", irq, 1'b1);
        send(8'h5a, 1'b1);
        check("irq_low_after_push", irq, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(posedge clock);
            #1;
            if (irq !== 1'b0) cnt++;
        end
        check("irq_low_during_frame", cnt, 0);
        @(posedge clock);
        #1;
        check("irq_after_stop", irq, 1'b1);
        bus_write(BASE, 8'h00);
        check("irq_disabled", irq, 1'b0);

        // Reset mid-frame during data bit 3 of 8'hAA
        send(8'haa, 1'b1);
        repeat (70) @(posedge clock);
        #1;
        read_status(st);
        check("midrst_busy", st, 8'h02);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_txd", txd, 1'b1);
        read_status(st);
        check("midrst_status_in_reset", st, 8'h0a);
        sb.delete();
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        read_status(st);
        check("midrst_status_after", st, 8'h0a);
        cnt = 0;
        for (int i = 0; i < 12 * CPB; i++) begin
            @(posedge clock);
            #1;
            if (txd !== 1'b1) cnt++;
        end
        check("midrst_no_residual", cnt, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
